fft16_bitrev_buffer: RTL

//   Input reorder stage for the 16-point FFT datapath; sits directly upstream of the radix-2 butterfly stage.

---
 rtl/fft16_bitrev_buffer.sv | 97 +++++++++
 1 files changed

// File: rtl/fft16_bitrev_buffer.sv
// Input reorder stage for the 16-point FFT: captures a natural-order frame and replays it bit-reversed.
// Define FFT_BITREV_PINGPONG_EN to alternate between two banks so fill overlaps replay.
module fft16_bitrev_buffer #(
    parameter int N        = 16,
    parameter int PTS_LOG2 = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [N-1:0]        i_re,
    input  logic [N-1:0]        i_im,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [N-1:0]        o_re,
    output logic [N-1:0]        o_im,
    output logic [PTS_LOG2-1:0] o_index,
    output logic                o_last
);
    localparam int PTS = 1 << PTS_LOG2;

    logic [2*N-1:0]        mem [2][PTS];
    logic [PTS_LOG2-1:0]   wr_cnt_reg;
    logic [PTS_LOG2-1:0]   rd_cnt_reg;
    logic [PTS_LOG2-1:0]   rd_addr;
    logic                  wr_bank_reg;
    logic                  rd_bank_reg;
    logic [1:0]            full_reg;
    logic [2*N-1:0]        rd_word;
    logic                  accept;
    logic                  load;
    logic                  fill_done;
    logic                  drain_done;

    // Replay address is the read counter with its bits mirrored.
    generate
        for (genvar gi = 0; gi < PTS_LOG2; gi++) begin : g_bitrev
            assign rd_addr[gi] = rd_cnt_reg[PTS_LOG2-1-gi];
        end
    endgenerate

    assign o_ready    = ~i_rst & ~full_reg[wr_bank_reg];
    assign accept     = i_valid & o_ready;
    assign fill_done  = accept & (&wr_cnt_reg);
    assign load       = full_reg[rd_bank_reg] & (~o_valid | i_ready);
    assign drain_done = load & (&rd_cnt_reg);
    assign rd_word    = mem[rd_bank_reg][rd_addr];

    always_ff @(posedge i_clk) begin
        if (accept) begin
            mem[wr_bank_reg][wr_cnt_reg] <= {i_re, i_im};
        end
    end

    // A bank is released as soon as its last sample moves into the output
    // register, so refill can start while that sample is still waiting.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_cnt_reg  <= '0;
            rd_cnt_reg  <= '0;
            wr_bank_reg <= 1'b0;
            rd_bank_reg <= 1'b0;
            full_reg    <= 2'b00;
            o_valid     <= 1'b0;
            o_re        <= '0;
            o_im        <= '0;
            o_index     <= '0;
            o_last      <= 1'b0;
        end else begin
            if (accept) begin
                wr_cnt_reg <= wr_cnt_reg + 1'b1;
                if (fill_done) begin
                    full_reg[wr_bank_reg] <= 1'b1;
`ifdef FFT_BITREV_PINGPONG_EN
                    wr_bank_reg <= ~wr_bank_reg;
`endif
                end
            end
            if (load) begin
                o_valid    <= 1'b1;
                o_re       <= rd_word[2*N-1:N];
                o_im       <= rd_word[N-1:0];
                o_index    <= rd_cnt_reg;
                o_last     <= &rd_cnt_reg;
                rd_cnt_reg <= rd_cnt_reg + 1'b1;
                if (drain_done) begin
                    full_reg[rd_bank_reg] <= 1'b0;
`ifdef FFT_BITREV_PINGPONG_EN
                    rd_bank_reg <= ~rd_bank_reg;
`endif
                end
            end else if (i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end
endmodule
